// File: rtl/mem_responder.sv
// Memory model answering cache line fetches and write-backs from a 2**IDX_BITS x 128-bit store.
// Latency: ready pulses RD_LATENCY / WR_LATENCY cycles after the accepting edge, for one cycle.
// Backpressure: none; mem_req is ignored while busy, nothing is queued.
package cache_pkg;
    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;
endpackage

module mem_responder
    import cache_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 5,
    parameter int IDX_BITS   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  mem_req_type  mem_req,
    output mem_data_type mem_data,
    output logic         busy,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);
    localparam int              LINES     = 2 ** IDX_BITS;
    localparam logic [3:0]      RD_LAT_M1 = 4'(RD_LATENCY - 1);
    localparam logic [3:0]      WR_LAT_M1 = 4'(WR_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            lat_cnt;
    logic [3:0]            fill_nib;
    logic [IDX_BITS-1:0]   req_idx;
    logic [127:0]          req_data;
    logic                  req_rw;
    logic [127:0]          store [LINES];
    logic [LINES-1:0]      line_valid;

    logic [IDX_BITS-1:0]   in_idx;
    logic [IDX_BITS-1:0]   sel_idx;
    logic                  sel_rw;
    logic [3:0]            in_lat_m1;
    logic [127:0]          resp_data;
    logic                  unused_addr_bits;

    assign in_idx           = mem_req.addr[IDX_BITS+3:4];
    assign unused_addr_bits = ^{mem_req.addr[31:IDX_BITS+4], mem_req.addr[3:0]};
    assign in_lat_m1        = mem_req.rw ? WR_LAT_M1 : RD_LAT_M1;

    // The response is registered on the edge entering RESP; with a one-cycle
    // latency that edge is the accepting one, so the live request is used.
    assign sel_idx = (state == IDLE) ? in_idx : req_idx;
    assign sel_rw  = (state == IDLE) ? mem_req.rw : req_rw;

    always_comb begin
        resp_data = '0;
        if (!sel_rw) begin
            resp_data = line_valid[sel_idx] ? store[sel_idx] : {32{fill_nib}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_data   <= '0;
            busy       <= 1'b0;
            lat_cnt    <= '0;
            fill_nib   <= 4'h1;
            rd_count   <= '0;
            wr_count   <= '0;
            line_valid <= '0;
            req_idx    <= '0;
            req_data   <= '0;
            req_rw     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req.valid) begin
                        req_idx  <= in_idx;
                        req_data <= mem_req.data;
                        req_rw   <= mem_req.rw;
                        lat_cnt  <= in_lat_m1;
                        busy     <= 1'b1;
                        if (in_lat_m1 == 4'd0) begin
                            state         <= RESP;
                            mem_data.data  <= resp_data;
                            mem_data.ready <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        state          <= RESP;
                        mem_data.data  <= resp_data;
                        mem_data.ready <= 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_data <= '0;
                    if (req_rw) begin
                        line_valid[req_idx] <= 1'b1;
                        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                    end else begin
                        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                        // fill nibble skips 0 so a fill line is never mistaken for cleared data
                        if (!line_valid[req_idx]) begin
                            fill_nib <= (fill_nib == 4'hF) ? 4'h1 : fill_nib + 4'h1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store is not reset; line_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && req_rw) begin
            store[req_idx] <= req_data;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder against a queue/array reference model.
module tb_mem_responder;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    mem_req_type  mem_req;
    mem_data_type mem_data;
    logic         busy;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    int           n_cmp = 0;
    int           n_bad = 0;

    logic [127:0] m_store [int];
    logic [3:0]   m_fill;
    int           m_rd;
    int           m_wr;
    bit           in_resp;
    logic [127:0] got;
    logic [127:0] d;

    mem_responder #(.RD_LATENCY(2), .WR_LATENCY(5), .IDX_BITS(8)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_data(mem_data),
        .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_store.delete();
        m_fill = 4'h1;
        m_rd   = 0;
        m_wr   = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},  128'(busy), 128'd0);
        chk({tag, "_ready"}, 128'(mem_data.ready), 128'd0);
        chk({tag, "_data"},  mem_data.data, 128'd0);
    endtask

    // Called at a negedge; returns at the negedge in which ready is seen.
    task automatic txn(input logic rw, input logic [31:0] addr, input logic [127:0] wd,
                       input bit scramble, output logic [127:0] resp);
        int           idx;
        int           lat;
        int           cyc;
        bit           seen;
        logic [127:0] exp;
        idx = int'(addr[11:4]);
        lat = rw ? 5 : 2;
        mem_req.addr  = addr;
        mem_req.data  = wd;
        mem_req.rw    = rw;
        mem_req.valid = 1'b1;
        if (in_resp) begin
            @(negedge clk);
            check_idle_outputs("gap");
            chk("gap_rd_count", 128'(rd_count), 128'(m_rd));
            chk("gap_wr_count", 128'(wr_count), 128'(m_wr));
        end
        if (rw) exp = '0;
        else if (m_store.exists(idx)) exp = m_store[idx];
        else exp = {32{m_fill}};
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_data.ready === 1'b1) begin
                seen = 1'b1;
            end else begin
                chk("wait_busy", 128'(busy), 128'd1);
                chk("wait_data_zero", mem_data.data, 128'd0);
                if (scramble) begin
                    mem_req.addr = $urandom;
                    mem_req.rw   = ~mem_req.rw;
                    mem_req.data = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        chk("resp_seen", 128'(seen), 128'd1);
        chk("latency", 128'(cyc), 128'(lat));
        chk("resp_data", mem_data.data, exp);
        chk("resp_busy", 128'(busy), 128'd1);
        resp = mem_data.data;
        if (rw) begin
            m_store[idx] = wd;
            m_wr++;
        end else begin
            if (!m_store.exists(idx)) m_fill = (m_fill == 4'hF) ? 4'h1 : m_fill + 4'h1;
            m_rd++;
        end
        in_resp = 1'b1;
    endtask

    task automatic idle(input int n);
        mem_req.valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_idle_outputs("idle");
        end
        in_resp = 1'b0;
    endtask

    task automatic do_reset();
        mem_req.valid = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_idle_outputs("rst");
        chk("rst_rd_count", 128'(rd_count), 128'd0);
        chk("rst_wr_count", 128'(wr_count), 128'd0);
        rst = 1'b0;
        in_resp = 1'b0;
    endtask

    initial begin
        mem_req = '0;
        in_resp = 1'b0;
        do_reset();

        // Read right after reset release: fill pattern 1, two-cycle latency.
        txn(1'b0, 32'h0000_0010, '0, 1'b0, got);
        chk("first_read", got, {32{4'h1}});
        idle(1);
        chk("first_rd_count", 128'(rd_count), 128'd1);

        // Write then read back; write ack carries zero data and does not advance fill.
        txn(1'b1, 32'h1000_0010, 128'hFACEB00C, 1'b0, got);
        chk("wr_ack_data", got, 128'd0);
        txn(1'b0, 32'h1000_0010, '0, 1'b0, got);
        chk("wr_rd_back", got, 128'hFACEB00C);
        txn(1'b0, 32'h0000_0020, '0, 1'b0, got);
        chk("fill_not_advanced", got, {32{4'h2}});

        // Write-back then allocate with valid held high throughout.
        d = {$urandom, $urandom, $urandom, $urandom};
        txn(1'b1, 32'h3000_0050, d, 1'b0, got);
        txn(1'b0, 32'h3000_0050, '0, 1'b0, got);
        chk("held_valid_readback", got, d);

        // Sixteen fresh lines from reset: fill nibbles 1..F then wrap to 1.
        idle(1);
        do_reset();
        for (int k = 0; k < 16; k++) begin
            logic [3:0] n;
            n = 4'((k % 15) + 1);
            txn(1'b0, 32'h0000_0400 + 32'(k * 16), '0, 1'b0, got);
            chk("fill_seq", got, {32{n}});
        end

        // Reset in the middle of a write's wait period aborts it.
        idle(1);
        mem_req = '{addr: 32'h2222_0010, data: 128'hDEAD, rw: 1'b1, valid: 1'b1};
        @(posedge clk);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        mem_req.valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check_idle_outputs("post_abort");
        end
        txn(1'b0, 32'h2222_0010, '0, 1'b0, got);
        chk("abort_fill", got, {32{4'h1}});
        idle(1);
        chk("abort_wr_count", 128'(wr_count), 128'd0);

        // Request fields changing during WAIT are ignored.
        d = {$urandom, $urandom, $urandom, $urandom};
        txn(1'b1, 32'h0000_0070, d, 1'b1, got);
        txn(1'b0, 32'h0000_0070, '0, 1'b1, got);
        chk("scramble_readback", got, d);

        // Randomized traffic over a small aliased line set.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = $urandom;
            a[11:4] = 8'h80 + 8'($urandom_range(0, 7));
            txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom},
                bit'($urandom_range(0, 1)), got);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        chk("final_rd_count", 128'(rd_count), 128'(m_rd));
        chk("final_wr_count", 128'(wr_count), 128'(m_wr));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RD_LATENCY, default 2, cycles from request acceptance to read response; legal range 1..15.
REQ-002 Parameter WR_LATENCY, default 5, cycles from request acceptance to write acknowledge; legal range 1..15.
REQ-003 Parameter IDX_BITS, default 8, backing-store index width; store holds 2**IDX_BITS lines of 128 bits, indexed by addr[IDX_BITS+3:4].
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 mem_req  input  mem_req_type (cache_pkg: addr 32, data 128, rw 1, valid 1)  request from cache; rw=1 write-back, rw=0 line fetch.
REQ-007 mem_data  output  mem_data_type (cache_pkg: data 128, ready 1)  response to cache.
REQ-008 busy  output  1  high while a request is accepted and not yet answered.
REQ-009 rd_count  output  16  number of completed reads, saturating.
REQ-010 wr_count  output  16  number of completed writes, saturating.

Function
REQ-011 FSM states: IDLE, WAIT, RESP.
REQ-012 IDLE: at a rising edge with mem_req.valid=1, latch addr, data and rw; load lat_cnt with the latency for rw minus 1; go to WAIT, or go directly to RESP if that latency is 1.
REQ-013 WAIT: decrement lat_cnt each cycle; go to RESP at the edge where lat_cnt equals 1.
REQ-014 Net timing: ready is high exactly LAT cycles after the accepting edge, where LAT is the selected latency.
REQ-015 RESP: mem_data.ready=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-016 A valid still high in the first IDLE cycle after RESP is treated as a new request; this covers a cache moving from write-back straight to allocate with valid held high.
REQ-017 Changes on mem_req during WAIT or RESP are ignored; only the latched request is served.
REQ-018 Write: in the RESP cycle mem_data.data = 0; latched data is committed to store[idx] and line_valid[idx] is set at the edge ending RESP.
REQ-019 Read of a line with line_valid=1: mem_data.data = store[idx] during RESP.
REQ-020 Read of a line with line_valid=0: mem_data.data = {32{fill_nib}}.
REQ-021 fill_nib: 4-bit register, reset 4'h1, advances by 1 after each such read and wraps 4'hF -> 4'h1; value 4'h0 never occurs.
REQ-022 Whenever ready=0, mem_data.data SHALL be 0.
REQ-023 busy=1 in WAIT and RESP, 0 in IDLE.
REQ-024 rd_count or wr_count increments at the edge ending RESP for the served rw; each holds at 16'hFFFF.
REQ-025 Write followed by read of the same line returns the written data, bit-exact.
REQ-026 Address bits above IDX_BITS+3 and bits [3:0] are ignored; aliasing lines share storage.

Reset
REQ-027 On rst=1, immediately and regardless of clock: state=IDLE, mem_data='0, busy=0, lat_cnt=0, fill_nib=4'h1, rd_count=0, wr_count=0, all line_valid=0.
REQ-028 Store contents are not reset; they are unobservable while line_valid=0.
REQ-029 Reset asserted in WAIT or RESP aborts the request: no store write, no counter update, no ready pulse after release.
REQ-030 The first request is accepted at the first rising edge after rst deasserts with valid=1.

Verification
REQ-031 Reset, then read addr 32'h0000_0010 held valid -> ready high exactly 2 cycles after accept, data=128'h1111...1111, rd_count=1.
REQ-032 Write addr 32'h1000_0010 data 128'hFACEB00C then read same addr -> ack after 5 cycles with data 0; read returns 128'h...FACEB00C; fill_nib not advanced.
REQ-033 Write-back with rw=1, then rw=0 at the same addr with valid held continuously -> two distinct ready pulses separated by exactly one IDLE cycle; second returns the written data.
REQ-034 Sixteen reads to distinct unwritten lines -> data nibbles 1,2,...,F,1; never 0.
REQ-035 Assert rst mid-WAIT of a write to 32'h2222_0010 -> ready never pulses; a later read of that addr returns fill pattern 1, wr_count=0.
REQ-036 Change mem_req.addr and rw during WAIT -> response uses the originally latched values; latency is unchanged.
